ipsxb_reg_bank_ctrl: RTL

Parametrised register bank behind the UART command decoder. It provides NUM_CTRL writable control words, NUM_STAT read-only status channels and a version word. Each control word has a per-bit self-clear mask and a write strobe. Reads complete over a toggle req/ack handshake with an ack timeout and an error flag. The block sits between the UART command parser and the DDR test datapath, replacing the fixed 16x32 control block.

---
 rtl/ipsxb_reg_bank_ctrl.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ipsxb_reg_bank_ctrl.sv
// Register bank behind the UART command decoder.
// Provides NUM_CTRL writable control words with per-bit self-clear, NUM_STAT
// read-only status channels and a version word. Writes commit on a divided
// strobe. Reads complete over a toggle req/ack handshake with a timeout.

module ipsxb_reg_bank_word #(
  parameter int            DW   = 32,
  parameter logic [DW-1:0] DFT  = '0,
  parameter logic [DW-1:0] SCLR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] word_o,
  output logic          wr_pulse_o
);

  logic [DW-1:0] word_q, word_d;
  logic          pulse_q;

  // A commit loads the word; the following cycle drops the pulse bits, so each
  // written 1 in a self-clear position is visible for exactly one cycle.
  always_comb begin
    word_d = word_q;
    if (wr_i)         word_d = wdata_i;
    else if (pulse_q) word_d = word_q & ~SCLR;
  end

  // Word storage and the one-cycle write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= DFT;
      pulse_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      pulse_q <= wr_i;
    end
  end

  assign word_o     = word_q;
  assign wr_pulse_o = pulse_q;

endmodule

module ipsxb_reg_bank_ctrl #(
  parameter int                     DW            = 32,
  parameter int                     AW            = 9,
  parameter int                     NUM_CTRL      = 16,
  parameter int                     NUM_STAT      = 4,
  parameter logic [NUM_CTRL*DW-1:0] CTRL_DFT      = '0,
  parameter logic [NUM_CTRL*DW-1:0] SELF_CLR_MASK = '0,
  parameter logic [31:0]            VERSION_ID    = 32'h2020_0729,
  parameter int                     WR_DIV        = 4,
  parameter int                     ACK_TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AW-1:0]            addr,
  input  logic [DW-1:0]            data,
  input  logic                     we,
  input  logic                     cmd_en,
  output logic                     cmd_done,
  output logic                     cmd_err,
  output logic [DW-1:0]            fifo_data,
  input  logic                     fifo_data_valid,
  output logic                     fifo_data_req,
  output logic                     read_req,
  input  logic                     read_ack,
  output logic [NUM_CTRL*DW-1:0]   ctrl_bus,
  output logic [NUM_CTRL-1:0]      ctrl_wr_pulse,
  input  logic [NUM_STAT*DW-1:0]   status_bus
);

  localparam int               DIVW     = (WR_DIV > 1) ? $clog2(WR_DIV) : 1;
  localparam int               TOW      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [DIVW-1:0]  DIV_LAST = DIVW'(WR_DIV - 1);
  localparam logic [TOW-1:0]   TO_LAST  = TOW'(ACK_TIMEOUT);
  localparam logic [AW-1:0]    NC_A     = AW'(NUM_CTRL);
  localparam logic [AW-1:0]    STAT_B   = AW'(1 << (AW - 1));
  localparam logic [DW-1:0]    VER      = DW'(VERSION_ID);

  typedef enum logic [1:0] {S_IDLE, S_WR_WAIT, S_RD_WAIT} state_t;

  state_t                      state_q, state_d;
  logic [DIVW-1:0]             div_q;
  logic                        clk_pos;
  logic [2:0]                  syn_q;
  logic                        ack_ev_q;
  logic [AW-1:0]               addr_q, addr_d;
  logic [DW-1:0]               data_q, data_d;
  logic [TOW-1:0]              to_q, to_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic [DW-1:0]               fifo_q, fifo_d;
  logic                        freq_q, freq_d;
  logic                        rreq_q, rreq_d;
  logic                        commit;
  logic                        wr_ok;
  logic                        to_hit;
  logic [DW-1:0]               rd_data;
  logic                        rd_err;
  logic [NUM_CTRL-1:0][DW-1:0] ctrl_w;
  logic [NUM_STAT-1:0][DW-1:0] stat_w;
  logic [NUM_CTRL-1:0]         word_wr;

  assign stat_w  = status_bus;
  assign clk_pos = (div_q == DIV_LAST);
  assign wr_ok   = (addr_q < NC_A);
  assign to_hit  = (to_q == TO_LAST);

  // Free-running commit divider; WR_DIV=1 makes every cycle a commit slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= clk_pos ? '0 : div_q + 1'b1;
  end

  // read_ack crosses in through three flops; the edge detect is registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syn_q    <= '0;
      ack_ev_q <= 1'b0;
    end else begin
      syn_q    <= {syn_q[1:0], read_ack};
      ack_ev_q <= syn_q[2] ^ syn_q[1];
    end
  end

  // Read mux: control words, status channels, version; anything else is an error
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b1;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (addr_q == AW'(i)) begin
        rd_data = ctrl_w[i];
        rd_err  = 1'b0;
      end
    end
    for (int k = 0; k < NUM_STAT; k++) begin
      if (addr_q == STAT_B + AW'(k)) begin
        rd_data = stat_w[k];
        rd_err  = 1'b0;
      end
    end
    if (&addr_q) begin
      rd_data = VER;
      rd_err  = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; an ack arriving with the timeout wins
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (cmd_en) state_d = we ? S_WR_WAIT : S_RD_WAIT;
      S_WR_WAIT: if (clk_pos) state_d = S_IDLE;
      S_RD_WAIT: if (ack_ev_q || to_hit) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs: next values of the registered outputs and command latches.
  // Commands outside IDLE and acks outside RD_WAIT fall through untouched.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    to_d   = to_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    fifo_d = fifo_q;
    freq_d = 1'b0;
    rreq_d = rreq_q;
    commit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_en) begin
          addr_d = addr;
          data_d = data;
          if (!we) begin
            rreq_d = ~rreq_q;
            to_d   = '0;
          end
        end
      end
      S_WR_WAIT: begin
        if (clk_pos) begin
          done_d = 1'b1;
          commit = wr_ok;
          err_d  = ~wr_ok;
        end
      end
      S_RD_WAIT: begin
        if (ack_ev_q) begin
          done_d = 1'b1;
          err_d  = rd_err;
          fifo_d = rd_data;
          freq_d = fifo_data_valid;
        end else if (to_hit) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Command latches and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      to_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      fifo_q <= '0;
      freq_q <= 1'b0;
      rreq_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      to_q   <= to_d;
      done_q <= done_d;
      err_q  <= err_d;
      fifo_q <= fifo_d;
      freq_q <= freq_d;
      rreq_q <= rreq_d;
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_word
    assign word_wr[g] = commit && (addr_q == AW'(g));
    ipsxb_reg_bank_word #(
      .DW   (DW),
      .DFT  (CTRL_DFT[g*DW +: DW]),
      .SCLR (SELF_CLR_MASK[g*DW +: DW])
    ) u_word (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_i       (word_wr[g]),
      .wdata_i    (data_q),
      .word_o     (ctrl_w[g]),
      .wr_pulse_o (ctrl_wr_pulse[g])
    );
  end

  assign ctrl_bus      = ctrl_w;
  assign cmd_done      = done_q;
  assign cmd_err       = err_q;
  assign fifo_data     = fifo_q;
  assign fifo_data_req = freq_q;
  assign read_req      = rreq_q;

endmodule
